mult_seq: RTL

MULT_SEQ -- requirements
Module: mult_seq

---
 rtl/mult_seq.sv | 54 +++++
 1 files changed

// File: rtl/mult_seq.sv
// mult_seq: sequential unsigned shift-and-add multiplier, one adder pass per cycle
module mult_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] mcand, acc_hi, acc_lo;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sum;
  logic last;
  // the carry-out lands in sum[WIDTH] and is shifted back into acc_hi
  assign sum = {1'b0, acc_hi} + {1'b0, acc_lo[0] ? mcand : {WIDTH{1'b0}}};
  assign last = cnt == CW'(WIDTH - 1);
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        mcand  <= a;
        acc_lo <= b;
        acc_hi <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        acc_hi <= sum[WIDTH:1];
        acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
        cnt    <= cnt + CW'(1);
      end
    end
  end
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  assign product_hi = acc_hi;
  assign product_lo = acc_lo;
endmodule
